// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART register-write framers: FSM state encoding,
// default start-of-frame marker and word-size helper.
package uart_frame_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_ADDR_ENC = 2'd1;
    localparam logic [1:0] ST_DATA_ENC = 2'd2;
    localparam logic [1:0] ST_CSUM_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ADDR = ST_ADDR_ENC,
        ST_DATA = ST_DATA_ENC,
        ST_CSUM = ST_CSUM_ENC
    } frame_state_e;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

    function automatic int unsigned bytes_per_word(input int unsigned reg_size);
        return reg_size / 32'd8;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte stall detector: counts enabled cycles since the last clear and
// flags expiry combinationally when the limit is reached without a clear.
module uart_frame_timeout #(
    parameter int unsigned IDLE_TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned TW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0] CNT_MAX = TW'(IDLE_TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Saturating count; a clear always wins so a byte on the expiry cycle is kept.
    always_comb begin
        cnt_d    = cnt_q;
        expire_c = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                expire_c = 1'b1;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_reg_frame_ctrl.sv
// Framed register-write controller: parses SOF, ADDR, DATA (MSB first), CSUM
// from the UART byte stream and turns each verified frame into one write strobe.
module uart_reg_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int unsigned REG_SIZE     = 32,
    parameter logic [7:0]  SOF_BYTE     = SOF_BYTE_DEF,
    parameter int unsigned IDLE_TIMEOUT = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_data_valid,
    output logic                reg_wr_en,
    output logic [7:0]          reg_wr_addr,
    output logic [REG_SIZE-1:0] reg_wr_data,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned NB = bytes_per_word(REG_SIZE);
    localparam int unsigned CW = $clog2(NB) + 1;

    frame_state_e        state_q, state_d;
    logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          addr_q, addr_d;
    logic [REG_SIZE-1:0] shreg_q, shreg_d;
    logic                reg_wr_en_q, reg_wr_en_d;
    logic [7:0]          reg_wr_addr_q, reg_wr_addr_d;
    logic [REG_SIZE-1:0] reg_wr_data_q, reg_wr_data_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;
    logic                tmo_expire_c;
    logic [CW-1:0]       cnt_inc;

    uart_frame_timeout #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (rx_data_valid || (state_q == ST_IDLE)),
        .en       (state_q != ST_IDLE),
        .expire_c (tmo_expire_c)
    );

    assign cnt_inc = byte_cnt_q + CW'(1);

    // Next-state, datapath and strobe generation.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        sum_d         = sum_q;
        addr_d        = addr_q;
        shreg_d       = shreg_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        frame_err_d   = 1'b0;

        if (tmo_expire_c) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end else if (rx_data_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SOF_BYTE) begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    addr_d     = rx_data;
                    sum_d      = rx_data;
                    byte_cnt_d = '0;
                    state_d    = ST_DATA;
                end
                ST_DATA: begin
                    shreg_d    = REG_SIZE'({shreg_q, rx_data});
                    sum_d      = sum_q + rx_data;
                    byte_cnt_d = cnt_inc;
                    if (cnt_inc == CW'(NB)) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (rx_data == sum_q) begin
                        reg_wr_en_d   = 1'b1;
                        reg_wr_addr_d = addr_q;
                        reg_wr_data_d = shreg_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            sum_q         <= '0;
            addr_q        <= '0;
            shreg_q       <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            sum_q         <= sum_d;
            addr_q        <= addr_d;
            shreg_q       <= shreg_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule
